// File: rtl/fdct_pkg.sv
// -----------------------------------------------------------------------------
// fdct_pkg
//   Shared constants and types for the 8-point stream forward DCT.
//   - FDCT_FRAC_BITS : fixed-point fraction of the cosine constants (2^-10)
//   - FDCT_C1..C7    : round(cos(k*pi/16) * 2^10 / 2) style orthonormal constants
//   - FDCT_ACC_GUARD : extra accumulator bits above the sample width
//   - fdct_acc_t / fdct_row_t : accumulator and row types at the default width
// -----------------------------------------------------------------------------
package fdct_pkg;

  localparam int FDCT_FRAC_BITS  = 10;
  localparam int FDCT_ROUND      = 512;
  localparam int FDCT_ACC_GUARD  = 14;
  localparam int FDCT_COEF_WIDTH = 32;
  localparam int FDCT_ACC_WIDTH  = FDCT_COEF_WIDTH + FDCT_ACC_GUARD;
  localparam int FDCT_DEST_WIDTH = 4;

  localparam int FDCT_C1 = 502;
  localparam int FDCT_C2 = 473;
  localparam int FDCT_C3 = 426;
  localparam int FDCT_C4 = 362;
  localparam int FDCT_C5 = 284;
  localparam int FDCT_C6 = 196;
  localparam int FDCT_C7 = 100;

  typedef logic signed [FDCT_ACC_WIDTH-1:0]  fdct_acc_t;
  typedef logic signed [FDCT_COEF_WIDTH-1:0] fdct_coef_t;
  typedef fdct_coef_t                        fdct_row_t [8];

endpackage

// File: rtl/fdct_round_sat.sv
// -----------------------------------------------------------------------------
// fdct_round_sat
//   Combinational round-half-up (add 2^(FRAC-1), arithmetic shift) followed by
//   saturation of an accumulator value to a signed COEF_WIDTH coefficient.
//   Ports:
//     i_acc  : signed accumulator, ACC_WIDTH bits, scaled by 2^FDCT_FRAC_BITS
//     o_coef : signed rounded and saturated coefficient, COEF_WIDTH bits
// -----------------------------------------------------------------------------
module fdct_round_sat
  import fdct_pkg::*;
#(
  parameter int COEF_WIDTH = 32,
  parameter int ACC_WIDTH  = COEF_WIDTH + FDCT_ACC_GUARD
) (
  input  logic signed [ACC_WIDTH-1:0]  i_acc,
  output logic signed [COEF_WIDTH-1:0] o_coef
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  localparam acc_t RND  = acc_t'(FDCT_ROUND);
  localparam acc_t MAXV = acc_t'($signed({1'b0, {(COEF_WIDTH-1){1'b1}}}));
  localparam acc_t MINV = acc_t'($signed({1'b1, {(COEF_WIDTH-1){1'b0}}}));

  acc_t w_shr;

  // Round half up, then clamp into the representable coefficient range.
  always_comb begin
    w_shr = (i_acc + RND) >>> FDCT_FRAC_BITS;
    if (w_shr > MAXV) begin
      o_coef = MAXV[COEF_WIDTH-1:0];
    end else if (w_shr < MINV) begin
      o_coef = MINV[COEF_WIDTH-1:0];
    end else begin
      o_coef = w_shr[COEF_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fdct_as_stream.sv
// -----------------------------------------------------------------------------
// fdct_as_stream
//   Five-stage pipelined 8-point 1D forward DCT on stream channels, one row in
//   and one coefficient row out per beat, full throughput with backpressure.
//   Ports:
//     aclk, aresetn        : clock, asynchronous active-low reset
//     in_ch_t_data/valid/last, in_ch_t_ready : input row x[0..7], x[i] at
//                            bits [i*CW +: CW]
//     out_ch_t_data/valid/last, out_ch_t_ready : output X[0..7], same packing
//     out_ch_t_strb/keep/dest : constant sideband (all ones / zero)
//   Stages: S1 butterfly, S2 even butterfly, S3 products, S4 sums,
//           S5 round/saturate into the output register.
// -----------------------------------------------------------------------------
module fdct_as_stream
  import fdct_pkg::*;
#(
  parameter int COEF_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [8*COEF_WIDTH-1:0]      in_ch_t_data,
  input  logic                         in_ch_t_valid,
  output logic                         in_ch_t_ready,
  input  logic                         in_ch_t_last,
  output logic [8*COEF_WIDTH-1:0]      out_ch_t_data,
  output logic                         out_ch_t_valid,
  input  logic                         out_ch_t_ready,
  output logic                         out_ch_t_last,
  output logic [COEF_WIDTH-1:0]        out_ch_t_strb,
  output logic [COEF_WIDTH-1:0]        out_ch_t_keep,
  output logic [FDCT_DEST_WIDTH-1:0]   out_ch_t_dest
);

  localparam int ACC = COEF_WIDTH + FDCT_ACC_GUARD;
  typedef logic signed [ACC-1:0] acc_t;

  localparam acc_t K_C2 = acc_t'(FDCT_C2);
  localparam acc_t K_C4 = acc_t'(FDCT_C4);
  localparam acc_t K_C6 = acc_t'(FDCT_C6);

  // Odd-part constants indexed 0..3 -> C1, C3, C5, C7.
  function automatic acc_t odd_coef(input int j);
    case (j)
      0:       return acc_t'(FDCT_C1);
      1:       return acc_t'(FDCT_C3);
      2:       return acc_t'(FDCT_C5);
      3:       return acc_t'(FDCT_C7);
      default: return acc_t'(0);
    endcase
  endfunction

  // Handshake / stage control
  logic w_ld1, w_ld2, w_ld3, w_ld4, w_ld5, w_in_ready;
  logic r_v1, r_v2, r_v3, r_v4;
  logic r_last1, r_last2, r_last3, r_last4;

  // Datapath
  acc_t w_x   [8];
  acc_t r_s1  [4];
  acc_t r_d1  [4];
  acc_t r_e2  [4];
  acc_t r_d2  [4];
  acc_t r_pc4e0, r_pc4e1, r_pc2e2, r_pc6e3, r_pc6e2, r_pc2e3;
  acc_t r_pd  [4][4];
  acc_t w_x4  [8];
  acc_t r_x4  [8];
  logic signed [COEF_WIDTH-1:0] w_rs [8];
  logic [8*COEF_WIDTH-1:0]      w_out_pack;

  logic [8*COEF_WIDTH-1:0] r_out_data;
  logic                    r_out_valid;
  logic                    r_out_last;

  // Load enables: a stage loads when its upstream holds a beat and it is
  // either empty or being emptied in the same cycle.
  always_comb begin
    w_ld5      = r_v4 && (!r_out_valid || out_ch_t_ready);
    w_ld4      = r_v3 && (!r_v4 || w_ld5);
    w_ld3      = r_v2 && (!r_v3 || w_ld4);
    w_ld2      = r_v1 && (!r_v2 || w_ld3);
    w_in_ready = !r_v1 || w_ld2;
    w_ld1      = in_ch_t_valid && w_in_ready;
  end

  // Stage valid flags: set on load, clear on drain without load.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_v4 <= 1'b0;
    end else begin
      if (w_ld1)      r_v1 <= 1'b1;
      else if (w_ld2) r_v1 <= 1'b0;
      if (w_ld2)      r_v2 <= 1'b1;
      else if (w_ld3) r_v2 <= 1'b0;
      if (w_ld3)      r_v3 <= 1'b1;
      else if (w_ld4) r_v3 <= 1'b0;
      if (w_ld4)      r_v4 <= 1'b1;
      else if (w_ld5) r_v4 <= 1'b0;
    end
  end

  // Sign-extend the incoming samples to accumulator width.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_x[i] = acc_t'($signed(in_ch_t_data[i*COEF_WIDTH +: COEF_WIDTH]));
    end
  end

  // S1: first butterfly, symmetric sums and differences.
  always_ff @(posedge aclk) begin
    if (w_ld1) begin
      for (int i = 0; i < 4; i++) begin
        r_s1[i] <= w_x[i] + w_x[7-i];
        r_d1[i] <= w_x[i] - w_x[7-i];
      end
      r_last1 <= in_ch_t_last;
    end
  end

  // S2: even-part butterfly; odd differences ride along.
  always_ff @(posedge aclk) begin
    if (w_ld2) begin
      r_e2[0] <= r_s1[0] + r_s1[3];
      r_e2[1] <= r_s1[1] + r_s1[2];
      r_e2[2] <= r_s1[0] - r_s1[3];
      r_e2[3] <= r_s1[1] - r_s1[2];
      for (int i = 0; i < 4; i++) begin
        r_d2[i] <= r_d1[i];
      end
      r_last2 <= r_last1;
    end
  end

  // S3: all constant products; C4 is applied to e0 and e1 separately so that
  // X0/X4 become a plain sum/difference in S4.
  always_ff @(posedge aclk) begin
    if (w_ld3) begin
      r_pc4e0 <= r_e2[0] * K_C4;
      r_pc4e1 <= r_e2[1] * K_C4;
      r_pc2e2 <= r_e2[2] * K_C2;
      r_pc6e3 <= r_e2[3] * K_C6;
      r_pc6e2 <= r_e2[2] * K_C6;
      r_pc2e3 <= r_e2[3] * K_C2;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_pd[i][j] <= r_d2[i] * odd_coef(j);
        end
      end
      r_last3 <= r_last2;
    end
  end

  // S4 sums. r_pd[i][j] = d_i * {C1,C3,C5,C7}[j].
  always_comb begin
    w_x4[0] = r_pc4e0 + r_pc4e1;
    w_x4[4] = r_pc4e0 - r_pc4e1;
    w_x4[2] = r_pc2e2 + r_pc6e3;
    w_x4[6] = r_pc6e2 - r_pc2e3;
    w_x4[1] = r_pd[0][0] + r_pd[1][1] + r_pd[2][2] + r_pd[3][3];
    w_x4[3] = r_pd[0][1] - r_pd[1][3] - r_pd[2][0] - r_pd[3][2];
    w_x4[5] = r_pd[0][2] - r_pd[1][0] + r_pd[2][3] + r_pd[3][1];
    w_x4[7] = r_pd[0][3] - r_pd[1][2] + r_pd[2][1] - r_pd[3][0];
  end

  // S4 register.
  always_ff @(posedge aclk) begin
    if (w_ld4) begin
      for (int k = 0; k < 8; k++) begin
        r_x4[k] <= w_x4[k];
      end
      r_last4 <= r_last3;
    end
  end

  genvar g;
  for (g = 0; g < 8; g++) begin : g_rs
    fdct_round_sat #(
      .COEF_WIDTH (COEF_WIDTH),
      .ACC_WIDTH  (ACC)
    ) u_rs (
      .i_acc  (r_x4[g]),
      .o_coef (w_rs[g])
    );
  end

  // Pack rounded coefficients into the output row layout.
  always_comb begin
    w_out_pack = '0;
    for (int k = 0; k < 8; k++) begin
      w_out_pack[k*COEF_WIDTH +: COEF_WIDTH] = w_rs[k];
    end
  end

  // S5 output register: only updated on load, so data/last hold while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_ld5) begin
      r_out_valid <= 1'b1;
      r_out_last  <= r_last4;
      r_out_data  <= w_out_pack;
    end else if (out_ch_t_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ch_t_ready  = w_in_ready;
  assign out_ch_t_valid = r_out_valid;
  assign out_ch_t_last  = r_out_last;
  assign out_ch_t_data  = r_out_data;
  assign out_ch_t_strb  = {COEF_WIDTH{1'b1}};
  assign out_ch_t_keep  = {COEF_WIDTH{1'b1}};
  assign out_ch_t_dest  = {FDCT_DEST_WIDTH{1'b0}};

endmodule

// File: tb/tb_fdct_as_stream.sv
// -----------------------------------------------------------------------------
// tb_fdct_as_stream
//   Scoreboard bench for fdct_as_stream with COEF_WIDTH=16. The driver pushes
//   the expected row on each accepted input beat; a separate monitor pops and
//   compares on every output handshake and watches stall stability.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fdct_as_stream;
  import fdct_pkg::*;

  localparam int CW = 16;
  localparam int DW = 8*CW;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_last;
  logic [CW-1:0]   out_strb;
  logic [CW-1:0]   out_keep;
  logic [FDCT_DEST_WIDTH-1:0] out_dest;

  fdct_as_stream #(.COEF_WIDTH(CW)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .in_ch_t_data   (in_data),
    .in_ch_t_valid  (in_valid),
    .in_ch_t_ready  (in_ready),
    .in_ch_t_last   (in_last),
    .out_ch_t_data  (out_data),
    .out_ch_t_valid (out_valid),
    .out_ch_t_ready (out_ready),
    .out_ch_t_last  (out_last),
    .out_ch_t_strb  (out_strb),
    .out_ch_t_keep  (out_keep),
    .out_ch_t_dest  (out_dest)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;
  bit   rnd_ready = 1'b0;
  logic fix_ready = 1'b1;

  // DCT matrix derived from the butterfly equations (rows X0..X7).
  localparam int T [8][8] = '{
    '{ 362,  362,  362,  362,  362,  362,  362,  362},
    '{ 502,  426,  284,  100, -100, -284, -426, -502},
    '{ 473,  196, -196, -473, -473, -196,  196,  473},
    '{ 426, -100, -502, -284,  284,  502,  100, -426},
    '{ 362, -362, -362,  362,  362, -362, -362,  362},
    '{ 284, -502,  100,  426, -426, -100,  502, -284},
    '{ 196, -473,  473, -196, -196,  473, -473,  196},
    '{ 100, -284,  426, -502,  502, -426,  284, -100}
  };

  function automatic logic [DW-1:0] model(input logic [DW-1:0] row);
    longint x [8];
    longint acc;
    longint r;
    logic [DW-1:0] res;
    res = '0;
    for (int n = 0; n < 8; n++) x[n] = longint'($signed(row[n*CW +: CW]));
    for (int k = 0; k < 8; k++) begin
      acc = 0;
      for (int n = 0; n < 8; n++) acc += longint'(T[k][n]) * x[n];
      r = (acc + 512) >>> 10;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      res[k*CW +: CW] = r[CW-1:0];
    end
    return res;
  endfunction

  function automatic logic [DW-1:0] pack8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
    int v [8];
    logic [DW-1:0] r;
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
    v[4] = a4; v[5] = a5; v[6] = a6; v[7] = a7;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*CW +: CW] = v[k][CW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] gen_row(input int seed);
    logic [DW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = ((seed * 37 + k * 1237 + seed * k * 11) % 8000) - 4000;
      r[k*CW +: CW] = v[CW-1:0];
    end
    return r;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Issue one beat; expected row is queued when the handshake is seen.
  task automatic send(input logic [DW-1:0] row, input logic last, input logic [DW-1:0] exp,
                      input bit chk_lat, input int gap);
    exp_t e;
    int   n;
    bit   ok;
    n  = 0;
    ok = 1'b0;
    in_data  = row;
    in_last  = last;
    in_valid = 1'b1;
    while (!ok) begin
      @(negedge aclk);
      if (in_ready) ok = 1'b1;
      else begin
        n++;
        if (n > 300) break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout act=in_ready_low exp=accept");
      in_valid = 1'b0;
      return;
    end
    e.data = exp; e.last = last; e.cyc = cyc; e.chk_lat = chk_lat;
    sbq.push_back(e);
    n_acc++;
    @(posedge aclk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (gap) begin @(posedge aclk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin @(posedge aclk); n++; end
    if (sbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout act=%0d exp=0 pending", sbq.size());
    end
    @(posedge aclk); #1;
  endtask

  // Output-ready driver.
  initial begin
    forever begin
      @(posedge aclk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready;
    end
  end

  // Monitor: compare on output handshake, check stability while stalled.
  exp_t          mon_e;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            prev_stall = 1'b0;
  always @(negedge aclk) begin
    if (!aresetn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", out_data, prev_data);
        check("stall_last", DW'(out_last), DW'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output act=%h exp=none", out_data);
        end else begin
          mon_e = sbq.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_last", DW'(out_last), DW'(mon_e.last));
          if (mon_e.chk_lat) check("latency", DW'(cyc - mon_e.cyc), DW'(5));
        end
      end
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
      prev_last  <= out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [DW-1:0] r;

    // Reset state
    repeat (3) @(posedge aclk); #1;
    check("rst_valid", DW'(out_valid), DW'(1'b0));
    check("rst_last",  DW'(out_last),  DW'(1'b0));
    check("rst_data",  out_data, '0);
    check("rst_in_ready", DW'(in_ready), DW'(1'b1));
    check("strb", DW'(out_strb), DW'(16'hFFFF));
    check("keep", DW'(out_keep), DW'(16'hFFFF));
    check("dest", DW'(out_dest), DW'(4'h0));
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Flat row of 100: DC only, 5-cycle latency
    send(pack8(100,100,100,100,100,100,100,100), 1'b0, pack8(283,0,0,0,0,0,0,0), 1'b1, 0);
    drain();

    // Impulse at x0: one column of the basis
    send(pack8(1024,0,0,0,0,0,0,0), 1'b0, pack8(362,502,473,426,362,284,196,100), 1'b1, 0);
    drain();

    // Alternating and ramp patterns against the model
    r = pack8(500,-500,500,-500,500,-500,500,-500);
    send(r, 1'b0, model(r), 1'b0, 0);
    r = pack8(-700,-500,-300,-100,100,300,500,700);
    send(r, 1'b0, model(r), 1'b0, 0);
    drain();

    // Saturation at both extremes
    send(pack8(32767,32767,32767,32767,32767,32767,32767,32767), 1'b0,
         pack8(32767,0,0,0,0,0,0,0), 1'b0, 0);
    send(pack8(-32768,-32768,-32768,-32768,-32768,-32768,-32768,-32768), 1'b0,
         pack8(-32768,0,0,0,0,0,0,0), 1'b0, 0);
    drain();

    // Backpressure: capacity of 5 beats, then in_ready must drop
    fix_ready = 1'b0;
    @(posedge aclk); #1;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          r = gen_row(i + 3);
          send(r, 1'b0, model(r), 1'b0, 0);
        end
      end
      begin
        repeat (10) @(posedge aclk);
        @(negedge aclk);
        check("stall_accepted", DW'(n_acc - base), DW'(5));
        check("stall_in_ready", DW'(in_ready), DW'(1'b0));
        fix_ready = 1'b1;
      end
    join
    drain();

    // t_last tracking under random valid/ready
    rnd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r = gen_row(i + 40);
      send(r, (i == 7) || (i == 15), model(r), 1'b0, int'($urandom_range(0, 2)));
    end
    drain();
    rnd_ready = 1'b0;
    fix_ready = 1'b1;
    repeat (2) @(posedge aclk); #1;

    // Reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      r = gen_row(i + 90);
      send(r, 1'b0, model(r), 1'b0, 0);
    end
    aresetn = 1'b0;
    #1;
    check("rst_mid_valid", DW'(out_valid), DW'(1'b0));
    sbq.delete();
    repeat (2) @(posedge aclk); #1;
    aresetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("post_rst_idle", DW'(out_valid), DW'(1'b0));
    end
    @(posedge aclk); #1;
    r = gen_row(123);
    send(r, 1'b1, model(r), 1'b1, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
